// File: rtl/otter_mux_pkg.sv
// Shared types and constants for the registered OTTER select mux.
// Exports the skid FSM state enum, channel limit, reset data and a pointer helper.
package otter_mux_pkg;

   localparam int   MUX_N_MAX    = 16;
   localparam logic MUX_RST_DATA = '0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } mux_pipe_state_t;

   // Wrapping successor of a channel index.
   function automatic int mux_next_idx(input int g, input int n);
      return (g + 1 >= n) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry output/skid register pair with a valid/ready sink side.
// Ports: CLK, RST, in_data/in_xfer/in_ready (fill), out_data/out_valid/out_ready (drain).
module mux_skid_buf
   import otter_mux_pkg::*;
#(
   parameter int DW = 35
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [DW-1:0] in_data,
   input  logic          in_xfer,
   output logic          in_ready,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   mux_pipe_state_t state;
   logic [DW-1:0]   skid_q;
   logic            out_xfer;

   assign out_xfer = out_valid & out_ready;

   // Ready comes only from registered state, so no path from out_ready.
   assign in_ready = (state != FULL);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= EMPTY;
         out_data  <= {DW{MUX_RST_DATA}};
         skid_q    <= {DW{MUX_RST_DATA}};
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (in_xfer) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= ONE;
               end
            end
            ONE: begin
               if (in_xfer && out_xfer) begin
                  out_data <= in_data;
               end else if (in_xfer) begin
                  skid_q <= in_data;
                  state  <= FULL;
               end else if (out_xfer) begin
                  out_valid <= 1'b0;
                  state     <= EMPTY;
               end
            end
            FULL: begin
               if (out_xfer) begin
                  out_data <= skid_q;
                  state    <= ONE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered, back-pressurable N-way select mux feeding a 2-entry skid stage.
// Ports: CLK, RST, in_data/in_valid/in_ready, sel, out_data/out_src/out_valid/out_ready, sel_err.
// MUX_RR_ARB_EN: replaces sel with a round-robin arbiter; sel_err is tied low.
module mux_sel_pipe
   import otter_mux_pkg::*;
#(
   parameter int W     = 32,
   parameter int N     = 6,
   parameter int SEL_W = $clog2(N)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [N*W-1:0]   in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   input  logic [SEL_W-1:0] sel,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_src,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             sel_err
);

   if (N < 2 || N > MUX_N_MAX) begin : g_bad_n
      $error("mux_sel_pipe: N out of range");
   end

   localparam int DW = W + SEL_W;

   logic [N-1:0]     gnt;
   logic [SEL_W-1:0] gnt_idx;
   logic [W-1:0]     gnt_data;
   logic             buf_ready;
   logic             in_xfer;
   logic [DW-1:0]    buf_out;

   assign in_ready = gnt & {N{buf_ready}};
   assign in_xfer  = |(in_valid & in_ready);

   // Only the granted slice is read, so X on other channels never leaks.
   always_comb begin
      gnt_data = '0;
      for (int k = 0; k < N; k++) begin
         if (gnt[k]) gnt_data = in_data[k*W +: W];
      end
   end

`ifdef MUX_RR_ARB_EN

   logic [SEL_W-1:0] ptr;
   logic             found;
   int               j;

   // Scan from ptr upward, wrapping, for the first valid channel.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int i = 0; i < N; i++) begin
         j = int'(ptr) + i;
         if (j >= N) j = j - N;
         if (!found && in_valid[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = SEL_W'(j);
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ptr <= '0;
      end else if (in_xfer) begin
         ptr <= SEL_W'(mux_next_idx(int'(gnt_idx), N));
      end
   end

   assign sel_err = 1'b0;

`else

   localparam logic [SEL_W:0] N_L = (SEL_W+1)'(N);

   logic sel_oor;

   assign sel_oor = ({1'b0, sel} >= N_L);

   always_comb begin
      gnt     = '0;
      gnt_idx = sel;
      for (int k = 0; k < N; k++) begin
         if (!sel_oor && sel == SEL_W'(k)) gnt[k] = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sel_err <= 1'b0;
      end else begin
         sel_err <= sel_oor;
      end
   end

`endif

   // Source index travels with the data so a later sel change
   // cannot relabel beats already captured.
   mux_skid_buf #(
      .DW (DW)
   ) u_skid (
      .CLK       (CLK),
      .RST       (RST),
      .in_data   ({gnt_idx, gnt_data}),
      .in_xfer   (in_xfer),
      .in_ready  (buf_ready),
      .out_data  (buf_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign out_data = buf_out[W-1:0];
   assign out_src  = buf_out[DW-1:W];

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Scoreboard bench for mux_sel_pipe (N=6, W=32), directed steps.
// Builds either the sel-driven or the MUX_RR_ARB_EN variant.
module tb_mux_sel_pipe;

   localparam int W  = 32;
   localparam int N  = 6;
   localparam int SW = 3;

   logic          CLK = 1'b0;
   logic          RST;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [SW-1:0] sel;
   logic [W-1:0]  out_data;
   logic [SW-1:0] out_src;
   logic          out_valid;
   logic          out_ready;
   logic          sel_err;

   int pass_cnt = 0;
   int total    = 0;
   int fail_cnt = 0;
   int n_pop    = 0;
   logic acc;
   logic [63:0] sbq[$];

   mux_sel_pipe #(.W(W), .N(N), .SEL_W(SW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sel_err   (sel_err)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int k, input logic [W-1:0] d);
      in_data[k*W +: W] = d;
   endtask

   // One clock: settle, pop/compare an output beat, push accepted inputs.
   task automatic cyc();
      logic [63:0] e;
      #1;
      chk("ready_onehot", 64'($countones(in_ready) <= 1), 64'd1);
      if (out_valid && out_ready) begin
         chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("sb_beat", {29'd0, out_src, out_data}, e);
            n_pop++;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (in_valid[k] && in_ready[k])
            sbq.push_back({29'd0, SW'(k), in_data[k*W +: W]});
      end
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      for (int i = 0; i < 20 && (sbq.size() != 0 || out_valid); i++)
         cyc();
      chk({tag, "_sb_empty"}, 64'(sbq.size()), 64'd0);
      chk({tag, "_idle"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      RST       = 1'b1;
      in_data   = 'x;
      in_valid  = '0;
      sel       = '0;
      out_ready = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_data", 64'(out_data), 64'd0);
      chk("rst_src", 64'(out_src), 64'd0);
      chk("rst_err", 64'(sel_err), 64'd0);
      @(negedge CLK);
      RST = 1'b0;

`ifdef MUX_RR_ARB_EN
      begin
         int rr_exp [6] = '{0, 2, 5, 0, 2, 5};
         sel = 3'd7;
         for (int k = 0; k < N; k++) set_ch(k, 32'hC000_0000 | k);
         in_valid  = 6'b100101;
         out_ready = 1'b1;
         for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_grant", 64'(in_ready), 64'(1 << rr_exp[i]));
            chk("rr_err", 64'(sel_err), 64'd0);
            cyc();
         end
         in_valid = '0;
         n_pop = 0;
         drain("rr");
         chk("rr_tail_pops", 64'(n_pop), 64'd1);
      end
`else
      // Basic select with X on unselected channels.
      sel = 3'd3;
      set_ch(3, 32'hDEAD_BEEF);
      in_valid  = 6'b001000;
      out_ready = 1'b1;
      #1;
      chk("basic_ready", 64'(in_ready), 64'b001000);
      cyc();
      chk("basic_valid", 64'(out_valid), 64'd1);
      chk("basic_data", 64'(out_data), 64'hDEAD_BEEF);
      chk("basic_src", 64'(out_src), 64'd3);
      in_valid = '0;
      drain("basic");

      // Back-pressure: two accepts fill the stage.
      sel = 3'd0;
      out_ready = 1'b0;
      set_ch(0, 32'h1);
      in_valid = 6'b000001;
      cyc();
      set_ch(0, 32'h2);
      cyc();
      set_ch(0, 32'h3);
      #1;
      chk("bp_full_ready", 64'(in_ready), 64'd0);
      cyc();
      chk("bp_hold_data", 64'(out_data), 64'h1);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      n_pop = 0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         acc = in_valid[0] && in_ready[0];
         cyc();
         if (acc) in_valid = '0;
         if (sbq.size() == 0 && !out_valid && in_valid == '0) break;
      end
      chk("bp_pops", 64'(n_pop), 64'd3);
      chk("bp_sb_empty", 64'(sbq.size()), 64'd0);

      // Out-of-range select.
      for (int k = 0; k < N; k++) set_ch(k, 32'h5000_0000 + k);
      in_valid = 6'h3F;
      sel = 3'd6;
      #1;
      chk("oor_ready", 64'(in_ready), 64'd0);
      cyc();
      chk("oor_err1", 64'(sel_err), 64'd1);
      chk("oor_valid1", 64'(out_valid), 64'd0);
      cyc();
      chk("oor_err2", 64'(sel_err), 64'd1);
      chk("oor_valid2", 64'(out_valid), 64'd0);
      sel = 3'd5;
      in_valid = '0;
      cyc();
      chk("oor_clear", 64'(sel_err), 64'd0);
      chk("oor_valid3", 64'(out_valid), 64'd0);

      // sel change while stalled keeps original source.
      sel = 3'd1;
      set_ch(1, 32'hAA);
      in_valid  = 6'b000010;
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      sel = 3'd4;
      set_ch(4, 32'hBB);
      in_valid = 6'b010000;
      #1;
      chk("stall_ready", 64'(in_ready), 64'b010000);
      cyc();
      chk("stall_src", 64'(out_src), 64'd1);
      in_valid = '0;
      n_pop = 0;
      drain("stall");
      chk("stall_pops", 64'(n_pop), 64'd2);

      // Asynchronous reset while FULL and sel_err set.
      sel = 3'd0;
      out_ready = 1'b0;
      set_ch(0, 32'h11);
      in_valid = 6'b000001;
      cyc();
      set_ch(0, 32'h22);
      cyc();
      in_valid = '0;
      sel = 3'd7;
      cyc();
      chk("pre_rst_err", 64'(sel_err), 64'd1);
      chk("pre_rst_valid", 64'(out_valid), 64'd1);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_valid", 64'(out_valid), 64'd0);
      chk("arst_data", 64'(out_data), 64'd0);
      chk("arst_src", 64'(out_src), 64'd0);
      chk("arst_err", 64'(sel_err), 64'd0);
      sbq.delete();
      sel = 3'd0;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("post_rst_ready", 64'(in_ready), 64'b000001);
      set_ch(0, 32'h33);
      in_valid  = 6'b000001;
      out_ready = 1'b1;
      cyc();
      chk("post_rst_data", 64'(out_data), 64'h33);
      in_valid = '0;
      drain("post_rst");
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
